// File: rtl/squeeze_bank_writer_pkg.sv
// Shared parameters and types for the squeeze-stage bank writer.
// Holds default geometry, the FSM encoding and the counter-width helper.
package squeeze_bank_writer_pkg;

   localparam int DW_DEF     = 16;
   localparam int LANES_DEF  = 8;
   localparam int IMG_W_DEF  = 111;
   localparam int IMG_H_DEF  = 111;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/squeeze_relu.sv
// Optional ReLU on one signed sample: negative values clamp to zero.
module squeeze_relu #(
   parameter int DW   = 16,
   parameter int RELU = 1
) (
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   assign dout = ((RELU != 0) && din[DW-1]) ? '0 : din;

endmodule

// File: rtl/squeeze_bank_writer.sv
// Packs the serial squeeze-conv sample stream into LANES-wide bank words,
// one write per spatial position, and pulses done at end of frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; upstream held off
// ST_FILL  | accepting samples into lane registers
// ST_WRITE | one-cycle bank write of the packed word at address pixel
// ST_DONE  | one-cycle done pulse, then back to idle
module squeeze_bank_writer
   import squeeze_bank_writer_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int RELU   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW-1:0]       in_data,
   output logic                wren,
   output logic [ADDR_W-1:0]   address1,
   output logic [DW*LANES-1:0] datain,
   output logic                busy,
   output logic                done
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int PW   = cnt_width(NPIX);
   localparam int LW   = cnt_width(LANES);
   localparam logic [PW-1:0] LAST_PIX  = PW'(NPIX - 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   state_t          state;
   logic [LW-1:0]   lane;
   logic [PW-1:0]   pixel;
   logic [DW-1:0]   lane_reg [LANES];
   logic [DW-1:0]   relu_q;
   logic            accept;

   squeeze_relu #(
      .DW   (DW),
      .RELU (RELU)
   ) u_relu (
      .din  (in_data),
      .dout (relu_q)
   );

   // in_ready is a flop that mirrors ST_FILL, so this is the handshake.
   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         lane     <= '0;
         pixel    <= '0;
         in_ready <= 1'b0;
         wren     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int k = 0; k < LANES; k++) lane_reg[k] <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_FILL;
                  lane     <= '0;
                  pixel    <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_FILL: begin
               if (accept) begin
                  lane_reg[lane] <= relu_q;
                  if (lane == LAST_LANE) begin
                     lane     <= '0;
                     state    <= ST_WRITE;
                     in_ready <= 1'b0;
                     wren     <= 1'b1;
                  end else begin
                     lane <= lane + LW'(1);
                  end
               end
            end
            ST_WRITE: begin
               wren <= 1'b0;
               if (pixel == LAST_PIX) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  pixel    <= pixel + PW'(1);
                  state    <= ST_FILL;
                  in_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Pixel counter doubles as the write address; it is held after the frame.
   assign address1 = ADDR_W'(pixel);

   for (genvar k = 0; k < LANES; k++) begin : g_pack
      assign datain[k*DW +: DW] = lane_reg[k];
   end

endmodule

// File: tb/tb_squeeze_bank_writer.sv
// Randomized bench for squeeze_bank_writer: a queue of accepted samples is
// regrouped into words and compared against every bank write.
module tb_squeeze_bank_writer;

   localparam int DW     = 16;
   localparam int LANES  = 8;
   localparam int IMG_W  = 5;
   localparam int IMG_H  = 3;
   localparam int ADDR_W = 32;
   localparam int NPIX   = IMG_W * IMG_H;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                start = 1'b0;
   logic                in_valid = 1'b0;
   logic [DW-1:0]       in_data = '0;

   logic                in_ready, wren, busy, done;
   logic [ADDR_W-1:0]   address1;
   logic [DW*LANES-1:0] datain;
   logic                in_ready_r, wren_r, busy_r, done_r;
   logic [ADDR_W-1:0]   address1_r;
   logic [DW*LANES-1:0] datain_r;

   squeeze_bank_writer #(
      .DW(DW), .LANES(LANES), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RELU(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .wren(wren), .address1(address1), .datain(datain),
      .busy(busy), .done(done)
   );

   squeeze_bank_writer #(
      .DW(DW), .LANES(LANES), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RELU(0)
   ) dut_raw (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_r),
      .in_data(in_data), .wren(wren_r), .address1(address1_r), .datain(datain_r),
      .busy(busy_r), .done(done_r)
   );

   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_errors = 0;
   logic [DW-1:0]    accq[$];
   int               wcount = 0;
   bit               last_wr = 1'b0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [127:0]     mon_exp, mon_raw;
   logic [DW-1:0]    mon_s;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] s);
      return ($signed(s) < 0) ? '0 : s;
   endfunction

   // Reference: every LANES accepted samples form the next word, written at
   // the next sequential address; done follows the write of the last word.
   always @(negedge clk) begin
      if (rst) begin
         if (done || last_wr) check_eq("done_pulse", done, last_wr);
         last_wr = 1'b0;
         if (wren) begin
            if (accq.size() < LANES) begin
               check_eq("word_underflow", accq.size(), LANES);
            end else begin
               mon_exp = '0;
               mon_raw = '0;
               for (int k = 0; k < LANES; k++) begin
                  mon_s = accq.pop_front();
                  mon_exp[k*DW +: DW] = relu_ref(mon_s);
                  mon_raw[k*DW +: DW] = mon_s;
               end
               check_eq("wr_addr", address1, wcount);
               check_eq("wr_data_relu", datain, mon_exp);
               check_eq("wr_data_raw", datain_r, mon_raw);
               check_eq("wr_raw_wren", wren_r, 1'b1);
               check_eq("wr_raw_addr", address1_r, wcount);
               check_eq("wr_ready_low", in_ready, 1'b0);
            end
            last_wr   = (wcount == NPIX - 1);
            last_addr = address1;
            wcount++;
         end
      end
   end

   task automatic send_one(input logic [DW-1:0] v, input int max_gap, input bit poke_start);
      int gap;
      bit ok;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      ok  = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
         @(negedge clk);
         in_valid = (gap == 0);
         in_data  = in_valid ? v : DW'($urandom);
         if (gap > 0) gap--;
         start = poke_start && ($urandom_range(0, 5) == 0);
         if (in_valid && in_ready) begin
            accq.push_back(v);
            ok = 1'b1;
         end
         @(posedge clk);
      end
      check_eq("send_accept", ok, 1'b1);
   endtask

   task automatic feed(input int n, input int max_gap, input bit poke_start);
      for (int i = 0; i < n; i++) send_one(DW'($urandom), max_gap, poke_start);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      start = 1'b0;
      #1;
      check_eq("rst_in_ready", {in_ready, in_ready_r}, 2'b00);
      check_eq("rst_wren", {wren, wren_r}, 2'b00);
      check_eq("rst_address1", address1 | address1_r, 0);
      check_eq("rst_datain", datain | datain_r, 0);
      check_eq("rst_busy", {busy, busy_r}, 2'b00);
      check_eq("rst_done", {done, done_r}, 2'b00);
      accq.delete();
      wcount = 0;
      last_wr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("start_busy", busy, 1'b1);
      check_eq("start_ready", in_ready, 1'b1);
   endtask

   initial begin
      time          t0, t1;
      logic [127:0] exp_w;

      repeat (2) @(negedge clk);
      do_reset();

      // Reset during FILL discards the partial word.
      do_start();
      feed(3, 0, 1'b0);
      do_reset();
      do_start();
      feed(LANES, 2, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("t1_words", wcount, 1);

      // Samples 1..8 back to back: write on the cycle after the 8th accept.
      do_reset();
      do_start();
      exp_w = '0;
      t0 = 0;
      for (int k = 0; k < LANES; k++) begin
         send_one(DW'(k + 1), 0, 1'b0);
         if (k == 0) t0 = $time;
         exp_w[k*DW +: DW] = DW'(k + 1);
      end
      t1 = $time;
      check_eq("t2_accept_span", t1 - t0, (LANES - 1) * 10);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("t2_wren", wren, 1'b1);
      check_eq("t2_addr", address1, 0);
      check_eq("t2_data", datain, exp_w);

      // ReLU clamp versus raw pass-through.
      do_reset();
      do_start();
      send_one(16'hFFFB, 0, 1'b0);
      send_one(16'h0007, 0, 1'b0);
      send_one(16'h8000, 0, 1'b0);
      send_one(16'h7FFF, 0, 1'b0);
      feed(LANES - 4, 0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("t3_relu_lo", datain[63:0], 64'h7FFF_0000_0007_0000);
      check_eq("t3_raw_lo", datain_r[63:0], 64'h7FFF_8000_0007_FFFB);

      // Random valid gaps over three positions.
      do_reset();
      do_start();
      feed(3 * LANES, 4, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("t4_words", wcount, 3);
      check_eq("t4_busy", busy, 1'b1);

      // Full frame with stray start pulses during FILL/WRITE and at DONE.
      do_reset();
      do_start();
      feed(NPIX * LANES, 1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("t5_done", done, 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("t5_busy_after", busy, 1'b0);
      check_eq("t5_done_after", done, 1'b0);
      repeat (4) @(negedge clk);
      check_eq("t5_idle_busy", busy, 1'b0);
      check_eq("t5_idle_ready", in_ready, 1'b0);
      check_eq("t5_words", wcount, NPIX);
      check_eq("t5_last_addr", last_addr, NPIX - 1);
      check_eq("t5_addr_hold", address1, NPIX - 1);
      check_eq("t5_leftover", accq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
